reg_write_sequencer: RTL

- Upstream stage of the register-strobe decoder.
- Parses a byte stream from the host link into register write frames.
- For each complete frame, emits the 4-bit register address, a one-cycle write strobe, the data-register select flag and a 16-bit write word.
- Enforces frame timing and reports framing errors.

---
 rtl/reg_write_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reg_write_sequencer.sv
// Host-link byte parser: assembles CMD/DATA_H/DATA_L frames into register
// write strobes for the register-strobe decoder, flagging bad opcodes and stalls.
module reg_write_sequencer #(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [3:0] OPC_REG        = 4'hA,
    parameter logic [3:0] OPC_DATA       = 4'hD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [3:0]  addr_out,
    output logic        strob_out,
    output logic        choose_data_reg,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        busy
);

    // A width of at least one bit keeps the counter legal when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GET_HI,
        GET_LO,
        STROBE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_toCnt;
    logic [3:0]        r_addr;
    logic              r_strob;
    logic              r_chooseData;
    logic [15:0]       r_wrData;
    logic              r_frameErr;

    logic              w_accept;
    logic [3:0]        w_opcode;
    logic              w_cmdOk;
    logic              w_inFrame;
    logic [CNT_W-1:0]  w_toCntNext;
    logic              w_timeout;

    assign w_accept    = rx_valid & rx_ready;
    assign w_opcode    = rx_data[7:4];
    assign w_cmdOk     = (w_opcode == OPC_REG) || (w_opcode == OPC_DATA);
    assign w_inFrame   = (r_state == GET_HI) || (r_state == GET_LO);
    assign w_toCntNext = r_toCnt + CNT_W'(1);

    // An accepted byte always beats the timeout in the cycle the limit is reached.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_inFrame && !w_accept &&
                       (w_toCntNext == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_toCnt      <= '0;
            r_addr       <= '0;
            r_strob      <= 1'b0;
            r_chooseData <= 1'b0;
            r_wrData     <= '0;
            r_frameErr   <= 1'b0;
        end else begin
            r_strob    <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_toCnt <= '0;
                    if (w_accept) begin
                        if (w_cmdOk) begin
                            r_addr       <= rx_data[3:0];
                            r_chooseData <= (w_opcode == OPC_DATA);
                            r_state      <= GET_HI;
                        end else begin
                            r_frameErr <= 1'b1;
                        end
                    end
                end
                GET_HI: begin
                    if (w_accept) begin
                        r_wrData[15:8] <= rx_data;
                        r_toCnt        <= '0;
                        r_state        <= GET_LO;
                    end else if (w_timeout) begin
                        r_toCnt    <= '0;
                        r_frameErr <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_toCnt <= w_toCntNext;
                    end
                end
                GET_LO: begin
                    if (w_accept) begin
                        r_wrData[7:0] <= rx_data;
                        r_toCnt       <= '0;
                        r_strob       <= 1'b1;
                        r_state       <= STROBE;
                    end else if (w_timeout) begin
                        r_toCnt    <= '0;
                        r_frameErr <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_toCnt <= w_toCntNext;
                    end
                end
                STROBE: begin
                    r_toCnt <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_toCnt <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready        = (r_state != STROBE);
    assign busy            = (r_state != IDLE);
    assign addr_out        = r_addr;
    assign strob_out       = r_strob;
    assign choose_data_reg = r_chooseData;
    assign wr_data         = r_wrData;
    assign frame_err       = r_frameErr;

endmodule
